// File: rtl/uart_program_loader.sv
// uart_program_loader
// Receives a program image over an 8N1 UART line and writes it, one 16-bit
// word at a time, into instruction memory through a spare write port. Words
// are placed downward starting at BASE_ADDR because the PC starts there and
// decrements. The CPU is held in reset while a frame is in flight.
//
// Frame: HEADER_BYTE, COUNT_HI, COUNT_LO, N x (word_hi, word_lo), CHK
//        CHK = XOR of every byte after the header, excluding CHK itself.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-low reset
//   rx           UART serial input, idle high, asynchronous to clk
//   mem_address  memory write address (15 bits)
//   mem_data     memory write data (16 bits)
//   mem_we       one-cycle write strobe per word
//   cpu_hold     high while a frame is being received
//   load_done    one-cycle pulse when a frame ends with a good checksum
//   load_error   sticky error flag, cleared by the next header or reset
module uart_program_loader #(
    parameter int          CLKS_PER_BIT = 1447,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5,
    parameter logic [14:0] BASE_ADDR    = 15'h7FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [14:0] mem_address,
    output logic [15:0] mem_data,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);
    localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       rx_state_q;
    logic            rx_meta_q, rx_sync_q;
    logic [CW-1:0]   clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            byte_valid_q;
    logic            frame_err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q   <= RX_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        clk_cnt_q  <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    // Mid-start-bit recheck rejects short glitches.
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_sync_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            bit_idx_q  <= '0;
                            rx_state_q <= RX_DATA;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_sync_q, shift_q[7:1]};   // LSB first
                        if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
                        else                   bit_idx_q  <= bit_idx_q + 1'b1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                default: begin // RX_STOP
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_sync_q) byte_valid_q <= 1'b1;
                        else           frame_err_q  <= 1'b1;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- Frame FSM ----------------
    typedef enum logic [2:0] {
        F_IDLE, F_CNT_HI, F_CNT_LO, F_DATA_HI, F_DATA_LO, F_CHECK, F_DONE, F_ERROR
    } frame_state_t;

    frame_state_t fstate_q;
    logic [7:0]   count_hi_q;
    logic [15:0]  remaining_q;
    logic [7:0]   word_hi_q;
    logic [7:0]   xor_q;
    logic         dec_pend_q;     // address steps down the cycle after a write
    logic [14:0]  mem_address_q;
    logic [15:0]  mem_data_q;
    logic         mem_we_q, cpu_hold_q, load_done_q, load_error_q;
    logic [15:0]  count_d;

    assign count_d = {count_hi_q, shift_q};

    always_ff @(posedge clk) begin
        if (!reset) begin
            fstate_q      <= F_IDLE;
            count_hi_q    <= '0;
            remaining_q   <= '0;
            word_hi_q     <= '0;
            xor_q         <= '0;
            dec_pend_q    <= 1'b0;
            mem_address_q <= BASE_ADDR;
            mem_data_q    <= '0;
            mem_we_q      <= 1'b0;
            cpu_hold_q    <= 1'b0;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            if (dec_pend_q) begin
                mem_address_q <= mem_address_q - 1'b1;   // wraps 0x0000 -> 0x7FFF
                dec_pend_q    <= 1'b0;
            end
            case (fstate_q)
                F_IDLE: begin
                    if (byte_valid_q && shift_q == HEADER_BYTE) begin
                        fstate_q      <= F_CNT_HI;
                        cpu_hold_q    <= 1'b1;
                        load_error_q  <= 1'b0;
                        xor_q         <= '0;
                        mem_address_q <= BASE_ADDR;
                    end
                end
                F_DONE, F_ERROR: fstate_q <= F_IDLE;
                default: begin
                    if (frame_err_q) begin
                        fstate_q     <= F_ERROR;
                        load_error_q <= 1'b1;
                        cpu_hold_q   <= 1'b0;
                    end else if (byte_valid_q) begin
                        case (fstate_q)
                            F_CNT_HI: begin
                                count_hi_q <= shift_q;
                                xor_q      <= xor_q ^ shift_q;
                                fstate_q   <= F_CNT_LO;
                            end
                            F_CNT_LO: begin
                                xor_q <= xor_q ^ shift_q;
                                if (count_d > 16'd32768) begin
                                    fstate_q     <= F_ERROR;
                                    load_error_q <= 1'b1;
                                    cpu_hold_q   <= 1'b0;
                                end else if (count_d == 16'd0) begin
                                    fstate_q <= F_CHECK;
                                end else begin
                                    remaining_q <= count_d;
                                    fstate_q    <= F_DATA_HI;
                                end
                            end
                            F_DATA_HI: begin
                                word_hi_q <= shift_q;
                                xor_q     <= xor_q ^ shift_q;
                                fstate_q  <= F_DATA_LO;
                            end
                            F_DATA_LO: begin
                                xor_q       <= xor_q ^ shift_q;
                                mem_data_q  <= {word_hi_q, shift_q};
                                mem_we_q    <= 1'b1;
                                dec_pend_q  <= 1'b1;
                                remaining_q <= remaining_q - 1'b1;
                                fstate_q    <= (remaining_q == 16'd1) ? F_CHECK : F_DATA_HI;
                            end
                            F_CHECK: begin
                                cpu_hold_q <= 1'b0;
                                if (shift_q == xor_q) begin
                                    fstate_q    <= F_DONE;
                                    load_done_q <= 1'b1;
                                end else begin
                                    fstate_q     <= F_ERROR;
                                    load_error_q <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign cpu_hold    = cpu_hold_q;
    assign load_done   = load_done_q;
    assign load_error  = load_error_q;
endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic [14:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_we, cpu_hold, load_done, load_error;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .HEADER_BYTE(8'hA5), .BASE_ADDR(15'h7FFF)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [30:0] got_q[$];     // {addr, data} observed
    logic [30:0] exp_q[$];     // {addr, data} from the model
    logic [7:0]  frame_q[$];   // bytes of the frame under test

    typedef struct {
        int           len;
        logic [127:0] data;    // bytes right-aligned, first byte most significant
        int           nw;
        int           done;
        int           err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (mem_we) begin
                got_q.push_back({mem_address, mem_data});
                check("hold_at_write", 64'(cpu_hold), 64'd1);
            end
            if (load_done) begin
                done_cnt++;
                check("hold_at_done", 64'(cpu_hold), 64'd0);
            end
        end
    end

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0; wait_bit();
        for (int k = 0; k < 8; k++) begin rx = b[k]; wait_bit(); end
        rx = stop; wait_bit();
        rx = 1'b1;
    endtask

    // Reference: parse the frame from its byte list with plain arithmetic.
    task automatic model_compute(output int mdone, output int merr);
        int i = 0;
        int cnt;
        logic [7:0] x, hi, lo;
        logic [14:0] a;
        exp_q.delete();
        mdone = 0; merr = 0;
        while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
        if (i + 2 >= frame_q.size()) return;
        cnt = int'({frame_q[i+1], frame_q[i+2]});
        x = frame_q[i+1] ^ frame_q[i+2];
        if (cnt > 32768) begin merr = 1; return; end
        a = 15'h7FFF;
        for (int w = 0; w < cnt; w++) begin
            hi = frame_q[i+3+2*w];
            lo = frame_q[i+4+2*w];
            x ^= hi ^ lo;
            exp_q.push_back({a, hi, lo});
            a = a - 15'd1;
        end
        if (frame_q[i+3+2*cnt] == x) mdone = 1;
        else                         merr  = 1;
    endtask

    task automatic run_frame(input string tag, input int tnw, input int tdone, input int terr);
        int mdone, merr;
        got_q.delete();
        done_cnt = 0;
        model_compute(mdone, merr);
        foreach (frame_q[k]) send_byte(frame_q[k], 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            check({tag, "_write"}, 64'(got_q[k]), 64'(exp_q[k]));
        check({tag, "_done"}, 64'(done_cnt), 64'(mdone));
        check({tag, "_err"}, 64'(load_error), 64'(merr));
        check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        if (tnw >= 0) begin
            check({tag, "_tbl_nw"}, 64'(got_q.size()), 64'(tnw));
            check({tag, "_tbl_done"}, 64'(done_cnt), 64'(tdone));
            check({tag, "_tbl_err"}, 64'(load_error), 64'(terr));
        end
        $display("frame %s: bytes=%0d writes=%0d done=%0d err=%0d", tag, frame_q.size(),
                 got_q.size(), done_cnt, load_error);
    endtask

    task automatic load_vec(input vec_t v);
        frame_q.delete();
        for (int k = 0; k < v.len; k++)
            frame_q.push_back(8'(v.data >> (8 * (v.len - 1 - k))));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 64'(mem_address), 64'h7FFF);
        check({tag, "_data"}, 64'(mem_data), 64'd0);
        check({tag, "_we"}, 64'(mem_we), 64'd0);
        check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
        check({tag, "_done"}, 64'(load_done), 64'd0);
        check({tag, "_err"}, 64'(load_error), 64'd0);
    endtask

    initial begin
        vecs[0] = '{8,  128'hA5_00_02_12_34_AB_CD_42, 2, 1, 0};
        vecs[1] = '{8,  128'hA5_00_02_12_34_AB_CD_43, 2, 0, 1};
        vecs[2] = '{4,  128'hA5_00_00_02, 0, 0, 1};
        vecs[3] = '{4,  128'hA5_00_00_00, 0, 1, 0};
        vecs[4] = '{10, 128'h3C_FF_A5_00_02_12_34_AB_CD_42, 2, 1, 0};
        vecs[5] = '{3,  128'hA5_80_01, 0, 0, 1};   // count 32769 is rejected

        reset = 1'b0;
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            run_frame($sformatf("vec%0d", v), vecs[v].nw, vecs[v].done, vecs[v].err);
            repeat (40) @(posedge clk);
            #1;
        end

        // Glitch in idle followed closely by a real frame.
        rx = 1'b0; repeat (4) @(posedge clk); #1;
        rx = 1'b1; repeat (14) @(posedge clk); #1;
        check("glitch_hold", 64'(cpu_hold), 64'd0);
        load_vec(vecs[0]);
        run_frame("after_glitch", 2, 1, 0);

        // Framing error while waiting for COUNT_LO.
        got_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("framing_err", 64'(load_error), 64'd1);
        check("framing_hold", 64'(cpu_hold), 64'd0);
        check("framing_nowrites", 64'(got_q.size()), 64'd0);
        load_vec(vecs[0]);
        run_frame("after_framing", 2, 1, 0);

        // Randomized well-formed frames, some with a corrupted checksum.
        for (int r = 0; r < 6; r++) begin
            int n;
            logic [7:0] x, b;
            frame_q.delete();
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                frame_q.push_back(b);
            end
            n = $urandom_range(1, 5);
            frame_q.push_back(8'hA5);
            frame_q.push_back(8'h00);
            frame_q.push_back(8'(n));
            x = 8'(n);
            for (int k = 0; k < 2 * n; k++) begin
                b = 8'($urandom_range(0, 255));
                frame_q.push_back(b);
                x ^= b;
            end
            if ($urandom_range(0, 1) == 1) x ^= 8'($urandom_range(1, 255));
            frame_q.push_back(x);
            run_frame($sformatf("rand%0d", r), -1, 0, 0);
            repeat (40) @(posedge clk);
            #1;
        end

        // Reset after the first data word has been written.
        got_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("mid_first_write", 64'(got_q.size()), 64'd1);
        check("mid_hold", 64'(cpu_hold), 64'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        reset = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        load_vec(vecs[0]);
        run_frame("after_reset", 2, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
